// File: rtl/uart_sim_pkg.sv
// Shared definitions for the simulated UART register slice.
// Holds the STAT_REG and CTRL_REG bit positions, the register map offsets
// and the character width shared by the RX status block and its FIFO.
package uart_sim_pkg;

  // STAT_REG bit positions
  localparam int STAT_RX_VALID = 0;
  localparam int STAT_RX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_INTR_EN  = 4;
  localparam int STAT_OVERRUN  = 5;

  // CTRL_REG bit positions
  localparam int CTRL_RST_TX   = 0;
  localparam int CTRL_RST_RX   = 1;
  localparam int CTRL_INTR_EN  = 4;

  // Register map offsets
  localparam logic [3:0] REG_RX_FIFO = 4'h0;
  localparam logic [3:0] REG_TX_FIFO = 4'h4;
  localparam logic [3:0] REG_STAT    = 4'h8;
  localparam logic [3:0] REG_CTRL    = 4'hC;

  // Character width carried through the RX path
  localparam int CHAR_W = 8;

endpackage

// File: rtl/uart_sim_fifo.sv
// First-word-fall-through character FIFO for the RX path.
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_clr         - synchronous clear of pointers/count (wins over push/pop)
//   i_push/i_wdata- write strobe and character
//   i_pop         - read strobe; ignored while empty
//   o_rdata       - head character, 8'h00 while empty
//   o_count       - occupancy 0..DEPTH
module uart_sim_fifo
  import uart_sim_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [CHAR_W-1:0]        i_wdata,
  input  logic                     i_pop,
  output logic [CHAR_W-1:0]        o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CHAR_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pop_eff;
  logic              push_ok;
  logic              wr_en;

  always_comb begin
    pop_eff = i_pop && (count_q != '0);
    // A full FIFO still takes a character when the head leaves the same cycle.
    push_ok = i_push && ((count_q != FULL_CNT) || pop_eff);
    wr_en   = push_ok && !i_clr;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (i_clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_eff) rptr_d = rptr_q + AW'(1);
      case ({push_ok, pop_eff})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is never reset; a zero count hides stale contents.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wptr_q] <= i_wdata;
  end

  assign o_rdata = (count_q != '0) ? mem_q[rptr_q] : '0;
  assign o_count = count_q;

endmodule

// File: rtl/uart_sim_rx_stat.sv
// RX character buffer plus STAT_REG / CTRL_REG / interrupt logic of the
// simulated UART.
// Ports:
//   i_clk, i_rst          - clock, asynchronous active-high reset
//   i_rx_valid, i_rx_data - received character strobe and value
//   i_rx_pop, o_rx_data   - RX_FIFO read strobe and FWFT head character
//   i_stat_rd             - STAT_REG read strobe (clears overrun)
//   i_ctrl_wr, i_ctrl_data- CTRL_REG write (bit1 clears RX FIFO, bit4 irq enable)
//   i_tx_empty, i_tx_full - TX path flags, reflected into the status word
//   o_stat                - status word
//   o_irq                 - single-cycle interrupt pulse
module uart_sim_rx_stat
  import uart_sim_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int STATW = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_pop,
  output logic [7:0]       o_rx_data,
  input  logic             i_stat_rd,
  input  logic             i_ctrl_wr,
  input  logic [7:0]       i_ctrl_data,
  input  logic             i_tx_empty,
  input  logic             i_tx_full,
  output logic [STATW-1:0] o_stat,
  output logic             o_irq
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0] rx_count;
  logic          rx_empty;
  logic          rx_full;
  logic          rx_clr;
  logic          overrun_q, overrun_d;
  logic          irq_en_q, irq_en_d;
  logic          tx_empty_q, tx_empty_d;
  logic          irq_q, irq_d;
  logic          unused_ctrl;

  assign rx_clr = i_ctrl_wr && i_ctrl_data[CTRL_RST_RX];

  uart_sim_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (rx_clr),
    .i_push  (i_rx_valid),
    .i_wdata (i_rx_data),
    .i_pop   (i_rx_pop),
    .o_rdata (o_rx_data),
    .o_count (rx_count)
  );

  assign rx_empty = (rx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);

  always_comb begin
    overrun_d  = overrun_q;
    irq_en_d   = irq_en_q;
    tx_empty_d = i_tx_empty;
    // Read clears first so a coincident drop keeps the flag set.
    if (i_stat_rd) overrun_d = 1'b0;
    // When full, any pop is effective, so only a push without pop drops data.
    if (i_rx_valid && rx_full && !i_rx_pop && !rx_clr) overrun_d = 1'b1;
    if (i_ctrl_wr) irq_en_d = i_ctrl_data[CTRL_INTR_EN];
    // Pushing into an empty FIFO is exactly the cycle before RX_VALID rises;
    // a clear in that cycle drops the push, so no rise follows.
    irq_d = irq_en_q && ((rx_empty && i_rx_valid && !rx_clr) ||
                         (i_tx_empty && !tx_empty_q));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overrun_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      tx_empty_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      overrun_q  <= overrun_d;
      irq_en_q   <= irq_en_d;
      tx_empty_q <= tx_empty_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    o_stat                = '0;
    o_stat[STAT_RX_VALID] = !rx_empty;
    o_stat[STAT_RX_FULL]  = rx_full;
    o_stat[STAT_TX_EMPTY] = i_tx_empty;
    o_stat[STAT_TX_FULL]  = i_tx_full;
    o_stat[STAT_INTR_EN]  = irq_en_q;
    o_stat[STAT_OVERRUN]  = overrun_q;
  end

  assign o_irq = irq_q;

  // TX reset and reserved control bits belong to other blocks.
  assign unused_ctrl = ^{i_ctrl_data[7:5], i_ctrl_data[3:2], i_ctrl_data[CTRL_RST_TX]};

endmodule

// File: tb/tb_uart_sim_rx_stat.sv
module tb_uart_sim_rx_stat;

  localparam int DEPTH = 16;
  localparam int STATW = 32;

  logic             clk;
  logic             i_rst;
  logic             i_rx_valid;
  logic [7:0]       i_rx_data;
  logic             i_rx_pop;
  logic [7:0]       o_rx_data;
  logic             i_stat_rd;
  logic             i_ctrl_wr;
  logic [7:0]       i_ctrl_data;
  logic             i_tx_empty;
  logic             i_tx_full;
  logic [STATW-1:0] o_stat;
  logic             o_irq;

  uart_sim_rx_stat #(
    .DEPTH (DEPTH),
    .STATW (STATW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_rx_valid  (i_rx_valid),
    .i_rx_data   (i_rx_data),
    .i_rx_pop    (i_rx_pop),
    .o_rx_data   (o_rx_data),
    .i_stat_rd   (i_stat_rd),
    .i_ctrl_wr   (i_ctrl_wr),
    .i_ctrl_data (i_ctrl_data),
    .i_tx_empty  (i_tx_empty),
    .i_tx_full   (i_tx_full),
    .o_stat      (o_stat),
    .o_irq       (o_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the FIFO as a queue plus the architectural flags.
  logic [7:0] m_q[$];
  bit         m_ovr;
  bit         m_irq_en;
  bit         m_txe_prev;
  bit         m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_stat();
    logic [31:0] e;
    e    = '0;
    e[0] = (m_q.size() != 0);
    e[1] = (m_q.size() == DEPTH);
    e[2] = i_tx_empty;
    e[3] = i_tx_full;
    e[4] = m_irq_en;
    e[5] = m_ovr;
    return e;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovr      = 0;
    m_irq_en   = 0;
    m_txe_prev = 0;
    m_irq      = 0;
  endtask

  // One clock cycle: drive, check outputs mid-cycle, advance the model.
  // Entered and left at posedge+1.
  task automatic step(input bit v, input logic [7:0] d, input bit p,
                      input bit sr, input bit cw, input logic [7:0] cd);
    int          pre;
    bit          full;
    bit          popeff;
    bit          clr;
    bit          nxt_ovr;
    logic [31:0] ed;
    i_rx_valid  = v;
    i_rx_data   = d;
    i_rx_pop    = p;
    i_stat_rd   = sr;
    i_ctrl_wr   = cw;
    i_ctrl_data = cd;
    @(negedge clk);
    ed = (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0;
    check("rx_data", 32'(o_rx_data), ed);
    check("stat", o_stat, exp_stat());
    check("irq", 32'(o_irq), 32'(m_irq));
    pre     = m_q.size();
    full    = (pre == DEPTH);
    popeff  = p && (pre > 0);
    clr     = cw && cd[1];
    nxt_ovr = m_ovr;
    if (sr) nxt_ovr = 0;
    if (v && full && !popeff && !clr) nxt_ovr = 1;
    if (clr) m_q.delete();
    else begin
      if (popeff) void'(m_q.pop_front());
      if (v && (!full || popeff)) m_q.push_back(d);
    end
    m_irq      = m_irq_en && ((pre == 0 && m_q.size() > 0) || (i_tx_empty && !m_txe_prev));
    m_txe_prev = i_tx_empty;
    if (cw) m_irq_en = cd[4];
    m_ovr = nxt_ovr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 8'h00, 0, 0, 0, 8'h00);
  endtask

  task automatic push(input logic [7:0] d);
    step(1, d, 0, 0, 0, 8'h00);
  endtask

  task automatic pop();
    step(0, 8'h00, 1, 0, 0, 8'h00);
  endtask

  initial begin
    i_rst       = 1'b1;
    i_rx_valid  = 1'b0;
    i_rx_data   = 8'h00;
    i_rx_pop    = 1'b0;
    i_stat_rd   = 1'b0;
    i_ctrl_wr   = 1'b0;
    i_ctrl_data = 8'h00;
    i_tx_empty  = 1'b1;
    i_tx_full   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", 32'(o_rx_data), 32'h0);
    check("rst_stat", o_stat, 32'h4);
    check("rst_irq", 32'(o_irq), 32'h0);
    i_rst = 1'b0;
    idle();

    // Ordered FWFT reads
    push(8'h41); push(8'h42); push(8'h43);
    check("ord_head0", 32'(o_rx_data), 32'h41);
    pop();
    check("ord_head1", 32'(o_rx_data), 32'h42);
    pop();
    check("ord_head2", 32'(o_rx_data), 32'h43);
    pop();
    check("ord_empty_data", 32'(o_rx_data), 32'h0);
    check("ord_empty_valid", 32'(o_stat[0]), 32'h0);

    // Overflow: 17 pushes, 17th dropped and flagged
    for (int i = 1; i <= 17; i++) push(8'(i));
    check("ovf_full", 32'(o_stat[1]), 32'h1);
    check("ovf_overrun", 32'(o_stat[5]), 32'h1);
    step(0, 8'h00, 0, 1, 0, 8'h00);
    check("ovf_rd_clear", 32'(o_stat[5]), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      check("ovf_pop_data", 32'(o_rx_data), 32'(i));
      pop();
    end
    check("ovf_17_absent", 32'(o_stat[0]), 32'h0);

    // Push+pop on a full FIFO
    for (int i = 1; i <= 16; i++) push(8'(8'h60 + i));
    step(1, 8'h5A, 1, 0, 0, 8'h00);
    check("fpp_full", 32'(o_stat[1]), 32'h1);
    check("fpp_no_ovr", 32'(o_stat[5]), 32'h0);
    check("fpp_head", 32'(o_rx_data), 32'h62);
    for (int i = 0; i < 15; i++) pop();
    check("fpp_last", 32'(o_rx_data), 32'h5A);
    pop();

    // Push+pop on empty stores the char
    step(1, 8'h77, 1, 0, 0, 8'h00);
    check("epp_head", 32'(o_rx_data), 32'h77);
    pop();

    // Interrupt on RX_VALID rise when enabled, none when disabled
    step(0, 8'h00, 0, 0, 1, 8'h10);
    push(8'h30);
    check("irq_pulse", 32'(o_irq), 32'h1);
    idle();
    check("irq_one_cycle", 32'(o_irq), 32'h0);
    pop();
    step(0, 8'h00, 0, 0, 1, 8'h00);
    push(8'h31);
    check("irq_disabled", 32'(o_irq), 32'h0);
    pop();

    // Interrupt on TX empty rise
    step(0, 8'h00, 0, 0, 1, 8'h10);
    i_tx_empty = 1'b0;
    idle();
    i_tx_empty = 1'b1;
    idle();
    check("irq_txe", 32'(o_irq), 32'h1);
    idle();
    step(0, 8'h00, 0, 0, 1, 8'h00);
    i_tx_empty = 1'b0;
    idle();
    i_tx_empty = 1'b1;
    idle();
    check("irq_txe_off", 32'(o_irq), 32'h0);

    // RX clear concurrent with a push; overrun preserved
    for (int i = 0; i < 17; i++) push(8'(8'h80 + i));
    step(1, 8'h55, 0, 0, 1, 8'h02);
    check("clr_valid", 32'(o_stat[0]), 32'h0);
    check("clr_ovr_kept", 32'(o_stat[5]), 32'h1);
    check("clr_data", 32'(o_rx_data), 32'h0);
    step(0, 8'h00, 0, 1, 0, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int pp;
      pp = ((i / 250) % 2 == 1) ? 70 : 25;
      if ($urandom_range(0, 19) == 0) i_tx_empty = ~i_tx_empty;
      if ($urandom_range(0, 19) == 0) i_tx_full = ~i_tx_full;
      step($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < pp,
           $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0, 8'($urandom));
    end

    // Asynchronous reset with 5 entries and overrun set
    step(0, 8'h00, 0, 0, 1, 8'h12);
    for (int i = 0; i < 17; i++) push(8'(8'hA0 + i));
    for (int i = 0; i < 11; i++) pop();
    check("ar_pre_ovr", 32'(o_stat[5]), 32'h1);
    check("ar_pre_valid", 32'(o_stat[0]), 32'h1);
    #2;
    i_rst = 1'b1;
    #1;
    check("ar_stat_lo", 32'(o_stat[1:0]), 32'h0);
    check("ar_ovr", 32'(o_stat[5]), 32'h0);
    check("ar_irq", 32'(o_irq), 32'h0);
    check("ar_data", 32'(o_rx_data), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    idle();
    push(8'h11);
    check("ar_after_head", 32'(o_rx_data), 32'h11);
    pop();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
